// File: rtl/valid_ready_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : valid_ready_fifo_sync
// Description : Single-clock FIFO with valid/ready handshakes on both sides.
//               Each pointer is seen by the opposite side only after a
//               configurable register chain, so occupancy and latency match
//               the asynchronous FIFO wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_ready_fifo_sync #(
  parameter int DATA_WIDTH        = 32,
  parameter int ROWS              = 4,
  parameter int M_FF_SYNC_WIDTH   = 2,
  localparam int ROW_ADDR_WIDTH   = $clog2(ROWS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic [ROW_ADDR_WIDTH-1:0] in_write_ptr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [ROW_ADDR_WIDTH-1:0] out_read_ptr
);

  // Pointers carry one extra wrap bit to tell full from empty.
  localparam int PTR_WIDTH = ROW_ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] ROWS_PTR = PTR_WIDTH'(ROWS);

  logic [DATA_WIDTH-1:0] mem [ROWS];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic [PTR_WIDTH-1:0]  wsync [M_FF_SYNC_WIDTH];
  logic [PTR_WIDTH-1:0]  rsync [M_FF_SYNC_WIDTH];
  logic [PTR_WIDTH-1:0]  wptr_s;
  logic [PTR_WIDTH-1:0]  rptr_s;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign wptr_s = wsync[M_FF_SYNC_WIDTH-1];
  assign rptr_s = rsync[M_FF_SYNC_WIDTH-1];

  // Write side compares its own pointer against the delayed read pointer,
  // so a freed row becomes usable only after the chain delay (conservative).
  assign full     = ((wptr - rptr_s) == ROWS_PTR);
  assign in_ready = ~full & ~reset;

  // Read side sees new words only after the write pointer crosses the chain.
  assign empty     = (wptr_s == rptr);
  assign out_valid = ~empty;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign in_write_ptr = wptr[ROW_ADDR_WIDTH-1:0];
  assign out_read_ptr = rptr[ROW_ADDR_WIDTH-1:0];

  // First-word fall-through: the head row is presented combinationally.
  assign out_data = mem[rptr[ROW_ADDR_WIDTH-1:0]];

  // Write pointer advances on every accepted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
    end else if (push) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Read pointer advances on every consumed word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr <= '0;
    end else if (pop) begin
      rptr <= rptr + 1'b1;
    end
  end

  // Storage array; cleared on reset so stale words can never resurface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr[ROW_ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  // Delay chains carrying each pointer to the opposite side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < M_FF_SYNC_WIDTH; i++) begin
        wsync[i] <= '0;
        rsync[i] <= '0;
      end
    end else begin
      wsync[0] <= wptr;
      rsync[0] <= rptr;
      for (int i = 1; i < M_FF_SYNC_WIDTH; i++) begin
        wsync[i] <= wsync[i-1];
        rsync[i] <= rsync[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_valid_ready_fifo_sync
// Description : Directed self-checking bench for valid_ready_fifo_sync
//               (ROWS=4, M_FF_SYNC_WIDTH=2, DATA_WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_valid_ready_fifo_sync;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_write_ptr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_read_ptr;

  int compared;
  int mismatched;

  valid_ready_fifo_sync #(
    .DATA_WIDTH      (32),
    .ROWS            (4),
    .M_FF_SYNC_WIDTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_write_ptr (in_write_ptr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_read_ptr (out_read_ptr)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    int occ;
    int cyc;
    logic push;
    logic pop;

    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    // ---------------- reset ----------------
    step();
    step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd0);
    check("rst_wptr",      {30'b0, in_write_ptr}, 32'd0);
    check("rst_rptr",      {30'b0, out_read_ptr}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    // ---------------- single word ----------------
    in_valid = 1'b1;
    in_data  = 32'h0000_00A5;
    step();                                   // edge N: push
    in_valid = 1'b0;
    check("sw_wptr_n",       {30'b0, in_write_ptr}, 32'd1);
    check("sw_out_valid_n",  {31'b0, out_valid}, 32'd0);
    step();                                   // N+1
    check("sw_out_valid_n1", {31'b0, out_valid}, 32'd0);
    step();                                   // N+2
    check("sw_out_valid_n2", {31'b0, out_valid}, 32'd1);
    check("sw_out_data",     out_data, 32'h0000_00A5);
    check("sw_rptr_head",    {30'b0, out_read_ptr}, 32'd0);
    out_ready = 1'b1;
    step();                                   // pop
    out_ready = 1'b0;
    check("sw_rptr_after_pop", {30'b0, out_read_ptr}, 32'd1);
    step();
    step();
    check("sw_empty_later", {31'b0, out_valid}, 32'd0);

    // Restart from clean pointers so the fill starts at row 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;

    // ---------------- fill ----------------
    in_valid = 1'b1;
    in_data  = 32'd1;
    step();
    check("fill_wptr1", {30'b0, in_write_ptr}, 32'd1);
    in_data = 32'd2;
    step();
    check("fill_wptr2", {30'b0, in_write_ptr}, 32'd2);
    in_data = 32'd3;
    step();
    check("fill_wptr3", {30'b0, in_write_ptr}, 32'd3);
    in_data = 32'd4;
    step();
    check("fill_wptr4", {30'b0, in_write_ptr}, 32'd0);
    check("fill_full",  {31'b0, in_ready}, 32'd0);
    in_data = 32'd5;                          // held, must not be taken
    step();
    step();
    check("fill_hold_wptr",  {30'b0, in_write_ptr}, 32'd0);
    check("fill_hold_ready", {31'b0, in_ready}, 32'd0);
    check("fill_out_valid",  {31'b0, out_valid}, 32'd1);
    check("fill_head",       out_data, 32'd1);

    // ---------------- drain from full ----------------
    out_ready = 1'b1;
    step();                                   // P1 pops 1
    check("drain_d2",     out_data, 32'd2);
    check("drain_rdy_p1", {31'b0, in_ready}, 32'd0);
    step();                                   // P2 pops 2
    check("drain_d3",     out_data, 32'd3);
    check("drain_rdy_p2", {31'b0, in_ready}, 32'd0);
    step();                                   // P3 pops 3
    check("drain_d4",     out_data, 32'd4);
    check("drain_rdy_p3", {31'b0, in_ready}, 32'd1);
    step();                                   // P4 pops 4, pushes 5
    in_valid = 1'b0;
    check("drain_wptr_p4",  {30'b0, in_write_ptr}, 32'd1);
    check("drain_empty_p4", {31'b0, out_valid}, 32'd0);
    step();
    check("drain_empty_p5", {31'b0, out_valid}, 32'd0);
    step();
    check("drain_valid_p6", {31'b0, out_valid}, 32'd1);
    check("drain_d5",       out_data, 32'd5);
    check("drain_rptr_p6",  {30'b0, out_read_ptr}, 32'd0);
    step();                                   // pops 5
    out_ready = 1'b0;
    check("drain_done", {31'b0, out_valid}, 32'd0);
    step();
    step();

    // ---------------- busy receiver ----------------
    sent = 0;
    recv = 0;
    occ  = 0;
    cyc  = 0;
    while (recv < 50 && cyc < 3000) begin
      in_valid  = (sent < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 32'h100 + 32'(sent);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      push = in_valid & in_ready;
      pop  = out_valid & out_ready;
      check("busy_no_overflow", {31'b0, (in_ready && occ == 4)}, 32'd0);
      if (pop) begin
        check("busy_data", out_data, 32'h100 + 32'(recv));
      end
      step();
      if (push) begin
        sent++;
        occ++;
      end
      if (pop) begin
        recv++;
        occ--;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("busy_count", 32'(recv), 32'd50);
    step();
    step();

    // ---------------- reset mid-operation ----------------
    in_valid = 1'b1;
    in_data  = 32'h0000_00B1;
    step();
    in_data  = 32'h0000_00B2;
    step();
    in_data  = 32'h0000_00B3;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_stored_valid", {31'b0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;                             // asynchronous assertion
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_wptr",  {30'b0, in_write_ptr}, 32'd0);
    check("mid_rst_rptr",  {30'b0, out_read_ptr}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mid_rel_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid_rel_empty", {31'b0, out_valid}, 32'd0);
      step();
    end
    in_valid = 1'b1;
    in_data  = 32'h0000_00C1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_new_valid", {31'b0, out_valid}, 32'd1);
    check("mid_new_data",  out_data, 32'h0000_00C1);
    check("mid_new_rptr",  {30'b0, out_read_ptr}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mid_new_popped", {31'b0, out_valid}, 32'd0);
    step();
    step();
    check("mid_final_empty", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
